// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage: word width, the canonical NOP,
// the fetch FSM states and the fault-cause encodings.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    MISALIGNED = 2'd1,
    RANGE      = 2'd2
  } fault_cause_e;

endpackage

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC register, fetch FSM, a one-entry output slot towards decode
// with valid/ready handshake, redirect handling and sticky fault reporting.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(IMEM_WORDS);

  fetch_state_e    state_q, state_d;
  fault_cause_e    cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] count_q, count_d;

  logic            slot_free;
  logic            handshake;
  logic            in_range;
  logic [XLEN-1:0] pc_plus4;

  assign slot_free = !vld_q || out_ready;
  assign handshake = vld_q && out_ready;
  assign in_range  = pc_q[XLEN-1:2] < WORD_LIMIT;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    vld_d     = vld_q;
    instr_d   = instr_q;
    slot_pc_d = slot_pc_q;
    pc4_d     = pc4_q;
    // A handshake is counted in every state, including the cycle a redirect flushes the slot.
    count_d   = count_q + {{(XLEN-1){1'b0}}, handshake};

    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          vld_d = 1'b0;
          if (redirect_target[1:0] != 2'b00) begin
            state_d = FAULT;
            cause_d = MISALIGNED;
          end else begin
            pc_d = redirect_target;
          end
        end else if (slot_free) begin
          if (!in_range) begin
            vld_d   = 1'b0;
            state_d = FAULT;
            cause_d = RANGE;
          end else begin
            vld_d     = 1'b1;
            instr_d   = imem_instr;
            slot_pc_d = pc_q;
            pc4_d     = pc_plus4;
            pc_d      = pc_plus4;
          end
        end
      end
      FAULT: vld_d = 1'b0;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      cause_q   <= NONE;
      pc_q      <= RESET_PC;
      vld_q     <= 1'b0;
      instr_q   <= NOP_INSTR;
      slot_pc_q <= '0;
      // Keeps out_pc_plus4 consistent with the reset out_pc of zero.
      pc4_q     <= 32'd4;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      vld_q     <= vld_d;
      instr_q   <= instr_d;
      slot_pc_q <= slot_pc_d;
      pc4_q     <= pc4_d;
      count_q   <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = vld_q;
  assign out_instr    = instr_q;
  assign out_pc       = slot_pc_q;
  assign out_pc_plus4 = pc4_q;
  assign fault        = (state_q == FAULT);
  assign fault_cause  = cause_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a transaction-level fetch model feeds a scoreboard queue,
// a negedge monitor checks the per-cycle status and pops on every handshake.
module tb_instr_fetch;
  import rv32i_pkg::*;

  localparam int IMEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  logic [31:0] prog [IMEM_WORDS];
  assign imem_instr = (imem_addr < 32'(IMEM_WORDS * 4)) ? prog[imem_addr[7:2]] : 32'hDEAD_BEEF;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(IMEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fetch_count    (fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  // Reference model: the slot is a queue of at most one delivered item.
  item_t       sb_q[$];
  item_t       slot_m[$];
  int unsigned m_pc    = 0;
  bit          m_boot  = 1'b1;
  bit          m_fault = 1'b0;
  int unsigned m_cause = 0;
  int unsigned m_count = 0;
  bit          in_reset = 1'b1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    slot_m.delete();
    m_pc    = 0;
    m_boot  = 1'b1;
    m_fault = 1'b0;
    m_cause = 0;
    m_count = 0;
  endtask

  task automatic model_step(input bit rdy, input bit rv, input logic [31:0] tgt);
    item_t it;
    if (slot_m.size() != 0 && rdy) m_count++;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_fault) begin
      // absorbing
    end else if (rv) begin
      slot_m.delete();
      if (tgt % 4 != 0) begin
        m_fault = 1'b1;
        m_cause = 1;
      end else begin
        m_pc = tgt;
      end
    end else if (slot_m.size() == 0 || rdy) begin
      slot_m.delete();
      if (m_pc >= IMEM_WORDS * 4) begin
        m_fault = 1'b1;
        m_cause = 2;
      end else begin
        it.pc    = m_pc;
        it.instr = prog[m_pc / 4];
        slot_m.push_back(it);
        m_pc += 4;
      end
    end
  endtask

  // Inputs are driven #1 after a rising edge; the expected handshake item is queued now.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] tgt);
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (slot_m.size() != 0 && rdy) sb_q.push_back(slot_m[0]);
    @(posedge clk);
    #1;
    model_step(rdy, rv, tgt);
  endtask

  task automatic do_reset();
    check("sb_empty_at_reset", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    in_reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  item_t got_e;

  always @(negedge clk) begin
    check("out_valid", {31'b0, out_valid}, {31'b0, slot_m.size() != 0});
    check("imem_addr", imem_addr, m_pc);
    check("fault", {31'b0, fault}, {31'b0, m_fault});
    check("fault_cause", {30'b0, fault_cause}, m_cause);
    check("fetch_count", fetch_count, m_count);
    if (in_reset) begin
      check("reset_out_instr", out_instr, NOP_INSTR);
      check("reset_out_pc", out_pc, 32'h0);
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handshake: unexpected delivery pc=%h instr=%h, expected none", out_pc, out_instr);
      end else begin
        got_e = sb_q.pop_front();
        check("out_pc", out_pc, got_e.pc);
        check("out_instr", out_instr, got_e.instr);
        check("out_pc_plus4", out_pc_plus4, got_e.pc + 32'd4);
      end
    end
  end

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'h100 + 32'($urandom_range(0, 15) * 4);
    if (r == 2) return 32'hF0 + 32'($urandom_range(0, 3) * 4);
    return 32'($urandom_range(0, IMEM_WORDS - 1) * 4);
  endfunction

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) prog[i] = $urandom;
    prog[0] = 32'h0070_0113;
    prog[1] = 32'h0000_0013;

    do_reset();

    // First delivery, stall, redirect while stalled.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 32'h20);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);

    // Misaligned redirect, then ignored redirects/ready while faulted.
    cycle(0, 1, 32'h22);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h0);
    do_reset();

    // Run off the end of instruction memory.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 32'hF0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    do_reset();

    // Redirect in the same cycle as a completing handshake.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    cycle(1, 1, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      if ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand_target());
      end
    end

    cycle(0, 0, 0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
